otter_cu_fsm: RTL and testbench

Multicycle control-unit state machine for the OTTER MCU. It sequences each instruction through fetch, execute, writeback and interrupt states. It drives the memory, PC and register-file write strobes, and it generates `rf_wr_sel`, the source select consumed by the register-file write-data mux. It sits between the instruction-memory output (opcode/func3 fields) and the datapath enables.

---
 rtl/otter_cu_fsm_if.sv | 37 +++
 rtl/otter_cu_fsm.sv | 176 +++++++++++++++++
 tb/tb_otter_cu_fsm.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_cu_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : otter_cu_fsm_if
//  Description : Instruction-field inputs and datapath strobes that connect
//                the OTTER multicycle control unit to the rest of the MCU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface otter_cu_fsm_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       intr;
    logic       PCWrite;
    logic       regWrite;
    logic       memWE2;
    logic       memRDEN1;
    logic       memRDEN2;
    logic [1:0] rf_wr_sel;
    logic       csr_WE;
    logic       int_taken;
    logic       mret_exec;
    logic       rst_out;

    // Control-unit side: consumes instruction fields, drives strobes
    modport master (
        input  opcode, func3, intr,
        output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
               rf_wr_sel, csr_WE, int_taken, mret_exec, rst_out
    );

    // Datapath side: supplies instruction fields, consumes strobes
    modport slave (
        output opcode, func3, intr,
        input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
               rf_wr_sel, csr_WE, int_taken, mret_exec, rst_out
    );
endinterface
`default_nettype wire

// File: rtl/otter_cu_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : otter_cu_fsm
//  Description : OTTER multicycle control unit. Sequences INIT -> FETCH ->
//                EXEC (-> WB for loads) (-> INTR) and decodes the datapath
//                strobes from the current state, opcode and func3.
//                Build option OTTER_INTR_EN compiles in the INTR state.
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_cu_fsm (
    input  wire logic         CLK,
    input  wire logic         RST,
    otter_cu_fsm_if.master    cu_bus
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] c_F3_MRET   = 3'b000;
    localparam logic [2:0] c_F3_CSRRW  = 3'b001;

    localparam logic [1:0] c_SEL_PC4   = 2'b00;
    localparam logic [1:0] c_SEL_CSR   = 2'b01;
    localparam logic [1:0] c_SEL_MEM   = 2'b10;
    localparam logic [1:0] c_SEL_ALU   = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
`ifdef OTTER_INTR_EN
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
`else
        ST_WB    = 3'd3
`endif
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    state_t     w_after_instr;

    logic       w_pc_write;
    logic       w_reg_write;
    logic       w_mem_we2;
    logic       w_mem_rden1;
    logic       w_mem_rden2;
    logic [1:0] w_rf_wr_sel;
    logic       w_csr_we;
    logic       w_int_taken;
    logic       w_mret_exec;
    logic       w_rst_out;

    // Where an instruction goes once it retires: interrupt entry or next fetch
`ifdef OTTER_INTR_EN
    assign w_after_instr = cu_bus.intr ? ST_INTR : ST_FETCH;
`else
    assign w_after_instr = ST_FETCH;
`endif

    // State register; reset wins from any state, including mid-instruction
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode from current state and instruction fields
    always_comb begin
        w_next_state = ST_INIT;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_we2    = 1'b0;
        w_mem_rden1  = 1'b0;
        w_mem_rden2  = 1'b0;
        w_rf_wr_sel  = c_SEL_PC4;
        w_csr_we     = 1'b0;
        w_int_taken  = 1'b0;
        w_mret_exec  = 1'b0;
        w_rst_out    = 1'b0;

        case (r_state)
            ST_INIT: begin
                w_rst_out    = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                w_mem_rden1  = 1'b1;
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                w_next_state = w_after_instr;
                w_pc_write   = 1'b1;
                case (cu_bus.opcode)
                    c_OP_LOAD: begin
                        // PC advances in WB, and interrupts wait until then
                        w_pc_write   = 1'b0;
                        w_mem_rden2  = 1'b1;
                        w_next_state = ST_WB;
                    end
                    c_OP_STORE: w_mem_we2 = 1'b1;
                    c_OP_BRANCH: ;
                    c_OP_LUI, c_OP_AUIPC, c_OP_OP, c_OP_OPIMM: begin
                        w_reg_write = 1'b1;
                        w_rf_wr_sel = c_SEL_ALU;
                    end
                    c_OP_JAL, c_OP_JALR: begin
                        w_reg_write = 1'b1;
                        w_rf_wr_sel = c_SEL_PC4;
                    end
                    c_OP_SYSTEM: begin
                        if (cu_bus.func3 == c_F3_MRET) begin
                            w_mret_exec = 1'b1;
                        end else if (cu_bus.func3 == c_F3_CSRRW) begin
                            w_reg_write = 1'b1;
                            w_csr_we    = 1'b1;
                            w_rf_wr_sel = c_SEL_CSR;
                        end
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                w_reg_write  = 1'b1;
                w_rf_wr_sel  = c_SEL_MEM;
                w_pc_write   = 1'b1;
                w_next_state = w_after_instr;
            end
`ifdef OTTER_INTR_EN
            ST_INTR: begin
                w_int_taken  = 1'b1;
                w_pc_write   = 1'b1;
                w_next_state = ST_FETCH;
            end
`endif
            default: w_next_state = ST_INIT;
        endcase

        // Reset masks every strobe immediately, before the state register updates
        if (RST) begin
            w_pc_write  = 1'b0;
            w_reg_write = 1'b0;
            w_mem_we2   = 1'b0;
            w_mem_rden1 = 1'b0;
            w_mem_rden2 = 1'b0;
            w_rf_wr_sel = c_SEL_PC4;
            w_csr_we    = 1'b0;
            w_int_taken = 1'b0;
            w_mret_exec = 1'b0;
            w_rst_out   = 1'b1;
        end
    end

    assign cu_bus.PCWrite   = w_pc_write;
    assign cu_bus.regWrite  = w_reg_write;
    assign cu_bus.memWE2    = w_mem_we2;
    assign cu_bus.memRDEN1  = w_mem_rden1;
    assign cu_bus.memRDEN2  = w_mem_rden2;
    assign cu_bus.rf_wr_sel = w_rf_wr_sel;
    assign cu_bus.csr_WE    = w_csr_we;
    assign cu_bus.int_taken = w_int_taken;
    assign cu_bus.mret_exec = w_mret_exec;
    assign cu_bus.rst_out   = w_rst_out;

endmodule
`default_nettype wire

// File: tb/tb_otter_cu_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otter_cu_fsm
//  Description : Self-checking bench for otter_cu_fsm. Each scenario drives a
//                per-cycle stimulus table, pushes the expected strobe vector
//                into a scoreboard queue and pops/compares it mid-cycle.
//                Interrupt expectations follow OTTER_INTR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_cu_fsm;

    // {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, rf_wr_sel[1:0],
    //  csr_WE, int_taken, mret_exec, rst_out}
    localparam logic [10:0] c_E_RST   = 11'b0_0_0_0_0_00_0_0_0_1;
    localparam logic [10:0] c_E_INIT  = 11'b0_0_0_0_0_00_0_0_0_1;
    localparam logic [10:0] c_E_FETCH = 11'b0_0_0_1_0_00_0_0_0_0;
    localparam logic [10:0] c_E_ALU   = 11'b1_1_0_0_0_11_0_0_0_0;
    localparam logic [10:0] c_E_LINK  = 11'b1_1_0_0_0_00_0_0_0_0;
    localparam logic [10:0] c_E_STORE = 11'b1_0_1_0_0_00_0_0_0_0;
    localparam logic [10:0] c_E_PCONLY= 11'b1_0_0_0_0_00_0_0_0_0;
    localparam logic [10:0] c_E_LOAD  = 11'b0_0_0_0_1_00_0_0_0_0;
    localparam logic [10:0] c_E_WB    = 11'b1_1_0_0_0_10_0_0_0_0;
    localparam logic [10:0] c_E_CSR   = 11'b1_1_0_0_0_01_1_0_0_0;
    localparam logic [10:0] c_E_MRET  = 11'b1_0_0_0_0_00_0_0_1_0;
    localparam logic [10:0] c_E_INTR  = 11'b1_0_0_0_0_00_0_1_0_0;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        irq;
        logic [10:0] exp;
    } step_t;

    logic        clk;
    logic        rst;
    logic [10:0] obs;
    logic [10:0] sb[$];
    int          n_checks;
    int          n_fail;

    otter_cu_fsm_if bus();

    otter_cu_fsm dut (
        .CLK    (clk),
        .RST    (rst),
        .cu_bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {bus.PCWrite, bus.regWrite, bus.memWE2, bus.memRDEN1,
                  bus.memRDEN2, bus.rf_wr_sel, bus.csr_WE, bus.int_taken,
                  bus.mret_exec, bus.rst_out};

    // Drive one cycle of inputs and record what the DUT must show this cycle
    task automatic apply(input step_t s);
        rst        = s.rst;
        bus.opcode = s.op;
        bus.func3  = s.f3;
        bus.intr   = s.irq;
        sb.push_back(s.exp);
    endtask

    task automatic test_reset();
        step_t s[$];
        logic [10:0] e;
        s.push_back('{1'b1, 7'h13, 3'd0, 1'b0, c_E_RST});
        s.push_back('{1'b1, 7'h13, 3'd0, 1'b0, c_E_RST});
        s.push_back('{1'b0, 7'h13, 3'd0, 1'b0, c_E_INIT});
        @(posedge clk); #1;
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset step %0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi();
        step_t s[$];
        logic [10:0] e;
        s.push_back('{1'b0, 7'h13, 3'd0, 1'b0, c_E_FETCH});
        s.push_back('{1'b0, 7'h13, 3'd0, 1'b0, c_E_ALU});
        s.push_back('{1'b0, 7'h17, 3'd0, 1'b0, c_E_FETCH});
        s.push_back('{1'b0, 7'h17, 3'd0, 1'b0, c_E_ALU});
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL addi step %0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_intr();
        step_t s[$];
        logic [10:0] e;
        s.push_back('{1'b0, 7'h03, 3'd2, 1'b1, c_E_FETCH});
        s.push_back('{1'b0, 7'h03, 3'd2, 1'b1, c_E_LOAD});
        s.push_back('{1'b0, 7'h03, 3'd2, 1'b1, c_E_WB});
`ifdef OTTER_INTR_EN
        s.push_back('{1'b0, 7'h03, 3'd2, 1'b1, c_E_INTR});
`endif
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL load_intr step %0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
        bus.intr = 1'b0;
    endtask

    task automatic test_system();
        step_t s[$];
        logic [10:0] e;
        s.push_back('{1'b0, 7'h73, 3'd1, 1'b0, c_E_FETCH});
        s.push_back('{1'b0, 7'h73, 3'd1, 1'b0, c_E_CSR});
        s.push_back('{1'b0, 7'h73, 3'd0, 1'b0, c_E_FETCH});
        s.push_back('{1'b0, 7'h73, 3'd0, 1'b0, c_E_MRET});
        s.push_back('{1'b0, 7'h73, 3'd2, 1'b0, c_E_FETCH});
        s.push_back('{1'b0, 7'h73, 3'd2, 1'b0, c_E_PCONLY});
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL system step %0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        logic [10:0] e;
        s.push_back('{1'b0, 7'h6F, 3'd0, 1'b0, c_E_FETCH});
        s.push_back('{1'b0, 7'h6F, 3'd0, 1'b0, c_E_LINK});
        s.push_back('{1'b0, 7'h23, 3'd2, 1'b0, c_E_FETCH});
        s.push_back('{1'b0, 7'h23, 3'd2, 1'b0, c_E_STORE});
        s.push_back('{1'b0, 7'h7F, 3'd0, 1'b0, c_E_FETCH});
        s.push_back('{1'b0, 7'h7F, 3'd0, 1'b0, c_E_PCONLY});
        s.push_back('{1'b0, 7'h63, 3'd0, 1'b0, c_E_FETCH});
        s.push_back('{1'b0, 7'h63, 3'd0, 1'b0, c_E_PCONLY});
        s.push_back('{1'b0, 7'h67, 3'd0, 1'b0, c_E_FETCH});
        s.push_back('{1'b0, 7'h67, 3'd0, 1'b0, c_E_LINK});
        s.push_back('{1'b0, 7'h37, 3'd0, 1'b0, c_E_FETCH});
        s.push_back('{1'b0, 7'h37, 3'd0, 1'b0, c_E_ALU});
        // Interrupt pulse only during FETCH must be lost
        s.push_back('{1'b0, 7'h33, 3'd0, 1'b1, c_E_FETCH});
        s.push_back('{1'b0, 7'h33, 3'd0, 1'b0, c_E_ALU});
        s.push_back('{1'b0, 7'h33, 3'd0, 1'b0, c_E_FETCH});
        // Interrupt held through EXEC of a non-load
        s.push_back('{1'b0, 7'h33, 3'd0, 1'b1, c_E_ALU});
`ifdef OTTER_INTR_EN
        s.push_back('{1'b0, 7'h33, 3'd0, 1'b1, c_E_INTR});
`endif
        s.push_back('{1'b0, 7'h33, 3'd0, 1'b0, c_E_FETCH});
        s.push_back('{1'b0, 7'h33, 3'd0, 1'b0, c_E_ALU});
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        logic [10:0] e;
        s.push_back('{1'b0, 7'h03, 3'd2, 1'b0, c_E_FETCH});
        s.push_back('{1'b0, 7'h03, 3'd2, 1'b0, c_E_LOAD});
        s.push_back('{1'b1, 7'h03, 3'd2, 1'b1, c_E_RST});
        s.push_back('{1'b0, 7'h03, 3'd2, 1'b1, c_E_INIT});
        s.push_back('{1'b0, 7'h03, 3'd2, 1'b0, c_E_FETCH});
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: got %b expected %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.opcode = 7'h13;
        bus.func3  = 3'd0;
        bus.intr   = 1'b0;
        test_reset();
        test_addi();
        test_load_intr();
        test_system();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
